// File: rtl/psg_pwm_dac.sv
// rtl/psg_pwm_dac.sv - PWM DAC for the PSG master sample; define PSG_PWM_DAC_SIGMA_DELTA_EN for sigma-delta output
module psg_pwm_dac #(
    parameter int SAMPLE_BITS   = 7,
    parameter int PRESCALE      = 1,
    parameter int PRESCALE_BITS = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    input  logic [SAMPLE_BITS-1:0] sample_in,
    output logic                   pwm_out,
    output logic                   period_start,
    output logic [SAMPLE_BITS-1:0] held_sample
);
    // A prescale of 0 is treated as 1 so the tick never stalls.
    localparam int PRE_EFF = (PRESCALE < 1) ? 1 : PRESCALE;
    localparam logic [PRESCALE_BITS-1:0] PRE_LAST = PRESCALE_BITS'(PRE_EFF - 1);
    localparam logic [SAMPLE_BITS-1:0]   CNT_LAST = SAMPLE_BITS'((2 ** SAMPLE_BITS) - 2);

    logic [PRESCALE_BITS-1:0] pre_cnt;
    logic [SAMPLE_BITS-1:0]   pwm_cnt;
    logic                     tick;
    logic                     cnt_zero;
    logic [SAMPLE_BITS-1:0]   h;
    logic                     bit_next;

    assign tick     = ena && (pre_cnt == '0);
    assign cnt_zero = (pwm_cnt == '0);
    // The sample is only taken at the first tick of a period so the duty never glitches.
    assign h        = cnt_zero ? sample_in : held_sample;

`ifdef PSG_PWM_DAC_SIGMA_DELTA_EN
    localparam logic [SAMPLE_BITS:0] MAX_W = {1'b0, {SAMPLE_BITS{1'b1}}};

    logic [SAMPLE_BITS-1:0] acc;
    logic [SAMPLE_BITS:0]   s;
    logic [SAMPLE_BITS:0]   s_wrap;

    assign s        = {1'b0, acc} + {1'b0, h};
    assign s_wrap   = s - MAX_W;
    assign bit_next = (s >= MAX_W);

    // Residue carries across periods; only reset clears it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (tick) begin
            acc <= bit_next ? s_wrap[SAMPLE_BITS-1:0] : s[SAMPLE_BITS-1:0];
        end
    end
`else
    assign bit_next = (pwm_cnt < h);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_cnt      <= '0;
            pwm_cnt      <= '0;
            held_sample  <= '0;
            pwm_out      <= 1'b0;
            period_start <= 1'b0;
        end else if (!ena) begin
            pwm_out      <= 1'b0;
            period_start <= 1'b0;
        end else begin
            pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + 1'b1;
            if (tick) begin
                held_sample  <= h;
                pwm_out      <= bit_next;
                pwm_cnt      <= (pwm_cnt == CNT_LAST) ? '0 : pwm_cnt + 1'b1;
                period_start <= cnt_zero;
            end else begin
                period_start <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_psg_pwm_dac.sv
// tb/tb_psg_pwm_dac.sv - randomized bench for psg_pwm_dac (PRESCALE 1 and 4 instances)
module tb_psg_pwm_dac;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [6:0] sample_in = 7'd0;
    logic       pwm0, ps0, pwm1, ps1;
    logic [6:0] held0, held1;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    psg_pwm_dac #(.SAMPLE_BITS(7), .PRESCALE(1), .PRESCALE_BITS(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .sample_in(sample_in),
        .pwm_out(pwm0), .period_start(ps0), .held_sample(held0)
    );
    psg_pwm_dac #(.SAMPLE_BITS(7), .PRESCALE(4), .PRESCALE_BITS(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .sample_in(sample_in),
        .pwm_out(pwm1), .period_start(ps1), .held_sample(held1)
    );

    // Reference: ticks are every P-th enabled cycle since reset; tick t sits at position t mod 127.
    longint m_en[2];
    longint m_total[2];
    int     m_held[2];
    bit     m_pwm[2];
    bit     m_ps[2];

    task automatic model_edge(input int i);
        longint p;
        longint pos;
        p = (i == 0) ? 1 : 4;
        if (!rst_n) begin
            m_en[i] = 0; m_total[i] = 0; m_held[i] = 0; m_pwm[i] = 0; m_ps[i] = 0;
        end else if (!ena) begin
            m_pwm[i] = 0; m_ps[i] = 0;
        end else begin
            if (m_en[i] % p == 0) begin
                pos = (m_en[i] / p) % 127;
                if (pos == 0) m_held[i] = int'(sample_in);
                m_ps[i] = (pos == 0);
`ifdef PSG_PWM_DAC_SIGMA_DELTA_EN
                // A one is emitted whenever the running sum crosses a multiple of 127.
                m_pwm[i] = ((m_total[i] + m_held[i]) / 127) != (m_total[i] / 127);
                m_total[i] += m_held[i];
`else
                m_pwm[i] = (pos < m_held[i]);
`endif
            end else begin
                m_ps[i] = 0;
            end
            m_en[i]++;
        end
    endtask

    function automatic logic [17:0] exp_all();
        return {m_pwm[0], m_ps[0], 7'(m_held[0]), m_pwm[1], m_ps[1], 7'(m_held[1])};
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        ena = 1'b1;
        sample_in = 7'($urandom_range(0, 127));
        rst_n = 1'b0;
        for (int n = 0; n < 3; n++) begin
            step();
            checks++;
            if ({pwm0, ps0, held0, pwm1, ps1, held1} !== 18'd0) begin
                failures++;
                $display("FAIL reset n=%0d got=%h want=0", n, {pwm0, ps0, held0, pwm1, ps1, held1});
            end
        end
        ena = 1'b0;
        step();
        checks++;
        if ({pwm0, ps0, held0, pwm1, ps1, held1} !== exp_all()) begin
            failures++;
            $display("FAIL reset_ena_low got=%h want=%h", {pwm0, ps0, held0, pwm1, ps1, held1}, exp_all());
        end
        ena = 1'b1;
    endtask

    task automatic test_basic();
        int ps_cnt = 0, ps_first = -1, ps_second = -1, hi = 0, first_hi = -1, last_hi = -1;
        int run = 0, max_run = 0;
        logic prev = 1'bx;
        sample_in = 7'd64;
        rst_n = 1'b1;
        for (int n = 1; n <= 254; n++) begin
            step();
            checks++;
            if ({pwm0, ps0, held0, pwm1, ps1, held1} !== exp_all()) begin
                failures++;
                $display("FAIL basic n=%0d got=%h want=%h", n, {pwm0, ps0, held0, pwm1, ps1, held1}, exp_all());
            end
            if (ps0) begin
                ps_cnt++;
                if (ps_first < 0) ps_first = n; else if (ps_second < 0) ps_second = n;
            end
            if (n <= 127 && pwm0) begin
                hi++;
                if (first_hi < 0) first_hi = n;
                last_hi = n;
            end
            run = (pwm0 === prev) ? run + 1 : 1;
            if (run > max_run) max_run = run;
            prev = pwm0;
        end
        checks++;
        if (ps_cnt != 2 || ps_first != 1 || ps_second != 128) begin
            failures++;
            $display("FAIL basic_period_start got cnt=%0d at %0d,%0d want 2 at 1,128", ps_cnt, ps_first, ps_second);
        end
        checks++;
        if (hi != 64) begin
            failures++;
            $display("FAIL basic_high_count got=%0d want=64", hi);
        end
`ifdef PSG_PWM_DAC_SIGMA_DELTA_EN
        checks++;
        if (max_run > 2) begin
            failures++;
            $display("FAIL sd_max_run got=%0d want<=2", max_run);
        end
`else
        checks++;
        if (first_hi != 1 || last_hi != 64) begin
            failures++;
            $display("FAIL basic_contiguous got=%0d..%0d want=1..64", first_hi, last_hi);
        end
`endif
    endtask

    task automatic test_extremes();
        int hi_a = 0, hi_b = 0;
        do_reset();
        sample_in = 7'd0;
        for (int n = 1; n <= 254; n++) begin
            step();
            checks++;
            if ({pwm0, ps0, held0, pwm1, ps1, held1} !== exp_all()) begin
                failures++;
                $display("FAIL extremes n=%0d got=%h want=%h", n, {pwm0, ps0, held0, pwm1, ps1, held1}, exp_all());
            end
            if (n <= 127) hi_a += int'(pwm0); else hi_b += int'(pwm0);
            if (n == 127) begin
                checks++;
                if (held0 !== 7'd0) begin
                    failures++;
                    $display("FAIL extremes_held0 got=%0d want=0", held0);
                end
                sample_in = 7'd127;
            end
        end
        checks++;
        if (hi_a != 0 || hi_b != 127 || held0 !== 7'd127) begin
            failures++;
            $display("FAIL extremes_counts got=%0d/%0d held=%0d want=0/127 held=127", hi_a, hi_b, held0);
        end
    endtask

    task automatic test_midchange();
        int hi_a = 0, hi_b = 0, bad_held = 0;
        logic [6:0] prev_held;
        do_reset();
        sample_in = 7'd10;
        prev_held = 7'd0;
        for (int n = 1; n <= 254; n++) begin
            step();
            checks++;
            if ({pwm0, ps0, held0, pwm1, ps1, held1} !== exp_all()) begin
                failures++;
                $display("FAIL midchange n=%0d got=%h want=%h", n, {pwm0, ps0, held0, pwm1, ps1, held1}, exp_all());
            end
            if (n <= 127) hi_a += int'(pwm0); else hi_b += int'(pwm0);
            if (held0 !== prev_held && !ps0) bad_held++;
            prev_held = held0;
            if (n == 51) sample_in = 7'd100;
        end
        checks++;
        if (hi_a != 10 || hi_b != 100 || bad_held != 0) begin
            failures++;
            $display("FAIL midchange_counts got=%0d/%0d badheld=%0d want=10/100/0", hi_a, hi_b, bad_held);
        end
    endtask

    task automatic test_prescale();
        int hi_a = 0, hi_b = 0, ps_cnt = 0, ps_bad = 0, r = 0;
        do_reset();
        sample_in = 7'd32;
        for (int n = 1; n <= 1016; n++) begin
            step();
            checks++;
            if ({pwm0, ps0, held0, pwm1, ps1, held1} !== exp_all()) begin
                failures++;
                $display("FAIL prescale n=%0d got=%h want=%h", n, {pwm0, ps0, held0, pwm1, ps1, held1}, exp_all());
            end
            if (ps1) begin
                ps_cnt++;
                if (n != 1 && n != 509) ps_bad++;
            end
            if (n <= 508) hi_a += int'(pwm1); else hi_b += int'(pwm1);
            if (n == 300) begin
                r = $urandom_range(0, 127);
                sample_in = 7'(r);
            end
        end
        checks++;
        if (ps_cnt != 2 || ps_bad != 0 || hi_a != 128 || hi_b != 4 * r) begin
            failures++;
            $display("FAIL prescale_counts got ps=%0d bad=%0d hi=%0d/%0d want ps=2 bad=0 hi=128/%0d",
                     ps_cnt, ps_bad, hi_a, hi_b, 4 * r);
        end
    endtask

    task automatic test_ena_reset();
        int hi = 0, hi_dis = 0, ps_at = -1;
        do_reset();
        sample_in = 7'd50;
        for (int n = 1; n <= 200; n++) begin
            step();
            checks++;
            if ({pwm0, ps0, held0, pwm1, ps1, held1} !== exp_all()) begin
                failures++;
                $display("FAIL ena n=%0d got=%h want=%h", n, {pwm0, ps0, held0, pwm1, ps1, held1}, exp_all());
            end
            if (n <= 147) hi += int'(pwm0);
            if (n >= 32 && n <= 51) hi_dis += int'(pwm0) + int'(pwm1);
            if (ps0 && n > 1 && ps_at < 0) ps_at = n;
            if (n == 31) ena = 1'b0;
            if (n == 51) ena = 1'b1;
        end
        checks++;
        if (hi != 50 || hi_dis != 0 || ps_at != 148) begin
            failures++;
            $display("FAIL ena_counts got hi=%0d dis=%0d ps=%0d want 50/0/148", hi, hi_dis, ps_at);
        end
        rst_n = 1'b0;
        ena = 1'b0;
        step();
        checks++;
        if ({pwm0, ps0, held0, pwm1, ps1, held1} !== 18'd0) begin
            failures++;
            $display("FAIL midreset got=%h want=0", {pwm0, ps0, held0, pwm1, ps1, held1});
        end
        rst_n = 1'b1;
        ena = 1'b1;
        step();
        checks++;
        if (ps0 !== 1'b1 || ps1 !== 1'b1 || held0 !== 7'd50) begin
            failures++;
            $display("FAIL after_reset got ps=%b%b held=%0d want ps=11 held=50", ps0, ps1, held0);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            ena = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 49) == 0) sample_in = 7'($urandom_range(0, 127));
            step();
            checks++;
            if ({pwm0, ps0, held0, pwm1, ps1, held1} !== exp_all()) begin
                failures++;
                $display("FAIL random n=%0d got=%h want=%h", n, {pwm0, ps0, held0, pwm1, ps1, held1}, exp_all());
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_en[i] = 0; m_total[i] = 0; m_held[i] = 0; m_pwm[i] = 0; m_ps[i] = 0;
        end
        #1;
        test_reset();
        test_basic();
        test_extremes();
        test_midchange();
        test_prescale();
        test_ena_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
